// File: rtl/mt_pkg.sv
// rtl/mt_pkg.sv - MT19937 / MT19937-64 constants, FSM encoding and mask helpers
package mt_pkg;

  typedef enum logic [1:0] {EMPTY, SEED, LOAD, RUN} mt_state_e;

  localparam int MT_R = 31;

  function automatic int mt_n(input int w);
    return (w == 64) ? 312 : 624;
  endfunction

  function automatic int mt_m(input int w);
    return (w == 64) ? 156 : 397;
  endfunction

  function automatic logic [63:0] mt_a(input int w);
    return (w == 64) ? 64'hB502_6F5A_A966_19E9 : 64'h0000_0000_9908_B0DF;
  endfunction

  function automatic logic [63:0] mt_f(input int w);
    return (w == 64) ? 64'd6364136223846793005 : 64'd1812433253;
  endfunction

  function automatic int mt_u(input int w);
    return (w == 64) ? 29 : 11;
  endfunction

  function automatic logic [63:0] mt_d(input int w);
    return (w == 64) ? 64'h5555_5555_5555_5555 : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int mt_s(input int w);
    return (w == 64) ? 17 : 7;
  endfunction

  function automatic logic [63:0] mt_b(input int w);
    return (w == 64) ? 64'h71D6_7FFF_EDA6_0000 : 64'h0000_0000_9D2C_5680;
  endfunction

  function automatic int mt_t(input int w);
    return (w == 64) ? 37 : 15;
  endfunction

  function automatic logic [63:0] mt_c(input int w);
    return (w == 64) ? 64'hFFF7_EEE0_0000_0000 : 64'h0000_0000_EFC6_0000;
  endfunction

  function automatic int mt_l(input int w);
    return (w == 64) ? 43 : 18;
  endfunction

  function automatic logic [63:0] mt_lower(input int w);
    return (w == 64) ? ((64'd1 << MT_R) - 64'd1) : ((64'd1 << MT_R) - 64'd1);
  endfunction

  function automatic logic [63:0] mt_upper(input int w);
    return ~mt_lower(w) & ((w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF);
  endfunction

endpackage

// File: rtl/mt_prng_core_if.sv
// rtl/mt_prng_core_if.sv - tempered-output valid/ready stream between core and consumer
interface mt_prng_core_if #(
  parameter int W = 32
);
  logic         rv_valid;
  logic         rv_ready;
  logic [W-1:0] rv;

  modport master (output rv_valid, output rv, input rv_ready);
  modport slave  (input rv_valid, input rv, output rv_ready);
endinterface

// File: rtl/mt_temper.sv
// rtl/mt_temper.sv - combinational MT tempering transform for W=32 or W=64
module mt_temper
  import mt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  localparam int           U = mt_u(W);
  localparam int           S = mt_s(W);
  localparam int           T = mt_t(W);
  localparam int           L = mt_l(W);
  localparam logic [W-1:0] D = W'(mt_d(W));
  localparam logic [W-1:0] B = W'(mt_b(W));
  localparam logic [W-1:0] C = W'(mt_c(W));

  logic [W-1:0] t1, t2, t3;

  assign t1 = x ^ ((x >> U) & D);
  assign t2 = t1 ^ ((t1 << S) & B);
  assign t3 = t2 ^ ((t2 << T) & C);
  assign y  = t3 ^ (t3 >> L);
endmodule

// File: rtl/mt_prng_core.sv
// rtl/mt_prng_core.sv - Mersenne Twister core: seed/load FSM, in-place twist, tempered stream
// Optional feature macro: MT_GEN_COUNT_EN adds the gen_count handshake counter.
module mt_prng_core
  import mt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           seed_en,
  input  logic [W-1:0]   seed,
  input  logic           load_value,
  input  logic [W-1:0]   value,
  output logic           busy,
  output logic           state_valid,
  mt_prng_core_if.master rv_if
`ifdef MT_GEN_COUNT_EN
  ,
  output logic [63:0]    gen_count
`endif
);
  localparam int            N     = mt_n(W);
  localparam int            M     = mt_m(W);
  localparam int            IW    = $clog2(N);
  localparam int            IW1   = IW + 1;
  localparam logic [W-1:0]  A     = W'(mt_a(W));
  localparam logic [W-1:0]  F     = W'(mt_f(W));
  localparam logic [W-1:0]  UPPER = W'(mt_upper(W));
  localparam logic [W-1:0]  LOWER = W'(mt_lower(W));
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW-1:0] ONE   = IW'(1);

  if (W != 32 && W != 64) begin : g_bad_width
    $error("mt_prng_core: W must be 32 or 64");
  end

  mt_state_e      state_q, state_d;
  logic [W-1:0]   st [N];
  logic [IW-1:0]  idx_q, idx_d, nxt_idx, m_idx, wr_idx;
  logic [IW1-1:0] m_sum;
  logic [W-1:0]   prev, y_mix, seed_word, twist_word, tempered, wr_data;
  logic           wr_en, gen, clr_valid;

  assign nxt_idx = (idx_q == LAST) ? '0 : idx_q + ONE;
  assign m_sum   = {1'b0, idx_q} + IW1'(M);
  assign m_idx   = (m_sum >= IW1'(N)) ? IW'(m_sum - IW1'(N)) : IW'(m_sum);

  assign prev       = st[idx_q - ONE];
  assign seed_word  = F * (prev ^ (prev >> (W - 2))) + W'(idx_q);
  // At idx=N-1, nxt_idx=0 deliberately picks up the already-twisted state[0].
  assign y_mix      = (st[idx_q] & UPPER) | (st[nxt_idx] & LOWER);
  assign twist_word = st[m_idx] ^ (y_mix >> 1) ^ (y_mix[0] ? A : '0);

  mt_temper #(.W(W)) u_temper (.x(twist_word), .y(tempered));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en     = 1'b0;
    wr_idx    = idx_q;
    wr_data   = twist_word;
    gen       = 1'b0;
    clr_valid = 1'b0;
    if (seed_en) begin
      state_d   = SEED;
      idx_d     = ONE;
      wr_en     = 1'b1;
      wr_idx    = '0;
      wr_data   = seed;
      clr_valid = 1'b1;
    end else if (load_value && state_q != LOAD) begin
      state_d   = LOAD;
      idx_d     = ONE;
      wr_en     = 1'b1;
      wr_idx    = '0;
      wr_data   = value;
      clr_valid = 1'b1;
    end else begin
      case (state_q)
        SEED: begin
          wr_en   = 1'b1;
          wr_data = seed_word;
          idx_d   = nxt_idx;
          if (idx_q == LAST) state_d = RUN;
        end
        LOAD: begin
          if (load_value) begin
            wr_en   = 1'b1;
            wr_data = value;
            idx_d   = nxt_idx;
            if (idx_q == LAST) state_d = RUN;
          end
        end
        RUN: begin
          if (!rv_if.rv_valid || rv_if.rv_ready) begin
            wr_en = 1'b1;
            gen   = 1'b1;
            idx_d = nxt_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= EMPTY;
      idx_q          <= '0;
      rv_if.rv_valid <= 1'b0;
      rv_if.rv       <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (clr_valid) begin
        rv_if.rv_valid <= 1'b0;
      end else if (gen) begin
        rv_if.rv_valid <= 1'b1;
        rv_if.rv       <= tempered;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) st[wr_idx] <= wr_data;
  end

  assign busy        = (state_q == SEED) || (state_q == LOAD);
  assign state_valid = (state_q == RUN);

`ifdef MT_GEN_COUNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gen_count <= '0;
    end else if (state_q != RUN && state_d == RUN) begin
      gen_count <= '0;
    end else if (rv_if.rv_valid && rv_if.rv_ready && gen_count != '1) begin
      gen_count <= gen_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mt_prng_core.sv
// tb/tb_mt_prng_core.sv - self-checking bench for mt_prng_core at W=32 and W=64
module tb_mt_prng_core;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int cyc = 0;
  always @(posedge tb_clk) cyc++;

  logic        n_rst;
  logic        seed_en32, load_value32, busy32, sv32;
  logic [31:0] seed32, value32;
  logic        seed_en64, load_value64, busy64, sv64;
  logic [63:0] seed64, value64;

  mt_prng_core_if #(.W(32)) if32 ();
  mt_prng_core_if #(.W(64)) if64 ();

`ifdef MT_GEN_COUNT_EN
  logic [63:0] gc32, gc64;
`endif

  mt_prng_core #(.W(32)) u_dut32 (
    .clk(tb_clk), .n_rst(n_rst), .seed_en(seed_en32), .seed(seed32),
    .load_value(load_value32), .value(value32), .busy(busy32),
    .state_valid(sv32), .rv_if(if32)
`ifdef MT_GEN_COUNT_EN
    , .gen_count(gc32)
`endif
  );

  mt_prng_core #(.W(64)) u_dut64 (
    .clk(tb_clk), .n_rst(n_rst), .seed_en(seed_en64), .seed(seed64),
    .load_value(load_value64), .value(value64), .busy(busy64),
    .state_valid(sv64), .rv_if(if64)
`ifdef MT_GEN_COUNT_EN
    , .gen_count(gc64)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: textbook MT with a whole-block regeneration every N outputs.
  longint unsigned ms [624];
  int              mi, mn, mm, mw;
  longint unsigned mmask, ma, mf, mupper, mlower;

  function automatic void model_cfg(input int w);
    mw = w;
    if (w == 32) begin
      mn = 624; mm = 397; ma = 64'h9908B0DF; mf = 64'd1812433253; mmask = 64'hFFFF_FFFF;
    end else begin
      mn = 312; mm = 156; ma = 64'hB5026F5AA96619E9; mf = 64'd6364136223846793005; mmask = '1;
    end
    mlower = (64'd1 << 31) - 64'd1;
    mupper = mmask & ~mlower;
  endfunction

  function automatic void model_seed(input longint unsigned s);
    ms[0] = s & mmask;
    for (int i = 1; i < mn; i++)
      ms[i] = (mf * (ms[i-1] ^ (ms[i-1] >> (mw - 2))) + 64'(i)) & mmask;
    mi = mn;
  endfunction

  function automatic longint unsigned model_next();
    longint unsigned y;
    if (mi >= mn) begin
      for (int i = 0; i < mn; i++) begin
        y = (ms[i] & mupper) | (ms[(i + 1) % mn] & mlower);
        ms[i] = ms[(i + mm) % mn] ^ (y >> 1) ^ (y[0] ? ma : 64'd0);
      end
      mi = 0;
    end
    y = ms[mi];
    mi++;
    if (mw == 32) begin
      y = y ^ (y >> 11);
      y = y ^ ((y << 7) & 64'h9D2C5680);
      y = y ^ ((y << 15) & 64'hEFC60000);
      y = y ^ (y >> 18);
    end else begin
      y = y ^ ((y >> 29) & 64'h5555555555555555);
      y = y ^ ((y << 17) & 64'h71D67FFFEDA60000);
      y = y ^ ((y << 37) & 64'hFFF7EEE000000000);
      y = y ^ (y >> 43);
    end
    return y & mmask;
  endfunction

  logic [63:0] m32 [10000];
  logic [63:0] m64 [10000];
  logic [63:0] d32 [10000];
  logic [63:0] d64 [10000];
  logic [31:0] lw  [624];

  typedef struct {
    bit          w64;
    int          n;
    logic [63:0] exp;
  } kat_t;
  kat_t kat [5];

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic wait_run(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (sel ? sv64 : sv32) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic get_word(input bit sel, output logic [63:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    for (int i = 0; i < 64; i++) begin
      if (sel ? (if64.rv_valid && if64.rv_ready) : (if32.rv_valid && if32.rv_ready)) begin
        v  = sel ? if64.rv : {32'h0, if32.rv};
        ok = 1'b1;
      end
      step();
      if (ok) break;
    end
  endtask

  task automatic pulse_seed32(input logic [31:0] s);
    seed32 = s;
    seed_en32 = 1'b1;
    step();
    seed_en32 = 1'b0;
  endtask

  task automatic load_words(input int from, input bit gaps);
    for (int i = from; i < 624; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) step();
      value32 = lw[i];
      load_value32 = 1'b1;
      step();
      load_value32 = 1'b0;
      if (i == 622) begin
        check("load_sv_before_last", sv32, 0);
        check("load_busy_before_last", busy32, 1);
      end
    end
    check("load_sv_after_last", sv32, 1);
    check("load_busy_after_last", busy32, 0);
  endtask

  task automatic model_load();
    model_cfg(32);
    for (int i = 0; i < 624; i++) ms[i] = 64'(lw[i]);
    mi = 624;
  endtask

  task automatic draw_vs_model(input string tag, input int cnt);
    logic [63:0] v;
    bit ok;
    for (int k = 0; k < cnt; k++) begin
      get_word(1'b0, v, ok);
      check($sformatf("%s_ok[%0d]", tag, k), ok, 1);
      check($sformatf("%s[%0d]", tag, k), v, model_next());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v, stall_rv;
    bit ok, stalled, seen;
    int t0, acc;

    kat[0] = '{1'b0, 1,     64'd3499211612};
    kat[1] = '{1'b0, 2,     64'd581869302};
    kat[2] = '{1'b0, 10000, 64'd4123659995};
    kat[3] = '{1'b1, 1,     64'd14514284786278117030};
    kat[4] = '{1'b1, 10000, 64'd9981545732273789042};

    model_cfg(32); model_seed(64'd5489);
    for (int k = 0; k < 10000; k++) m32[k] = model_next();
    model_cfg(64); model_seed(64'd5489);
    for (int k = 0; k < 10000; k++) m64[k] = model_next();

    n_rst = 1'b0;
    seed_en32 = 0; load_value32 = 0; seed32 = 0; value32 = 0;
    seed_en64 = 0; load_value64 = 0; seed64 = 0; value64 = 0;
    if32.rv_ready = 1'b0;
    if64.rv_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", busy32, 0);
    check("rst_state_valid", sv32, 0);
    check("rst_rv_valid", if32.rv_valid, 0);
    check("rst_rv", if32.rv, 0);
    check("rst_rv_valid64", if64.rv_valid, 0);
    n_rst = 1'b1;
    step();

    // W=32 seeded stream, latency and no-bubble throughput
    if32.rv_ready = 1'b1;
    pulse_seed32(32'd5489);
    check("seed_busy", busy32, 1);
    check("seed_sv", sv32, 0);
    wait_run(1'b0, ok);
    check("seed32_reaches_run", ok, 1);
    check("run_busy", busy32, 0);
    check("first_latency_before", if32.rv_valid, 0);
    step();
    check("first_latency_after", if32.rv_valid, 1);
    t0 = cyc;
    for (int k = 0; k < 10000; k++) begin
      get_word(1'b0, v, ok);
      d32[k] = v;
      check($sformatf("seq32[%0d]", k), v, m32[k]);
      if (!ok) break;
    end
    check("no_bubbles", 64'(cyc - t0), 64'd10000);
`ifdef MT_GEN_COUNT_EN
    check("gen_count32", gc32, 64'd10000);
`endif

    // W=64 seeded stream
    if32.rv_ready = 1'b0;
    if64.rv_ready = 1'b1;
    seed64 = 64'd5489;
    seed_en64 = 1'b1;
    step();
    seed_en64 = 1'b0;
    wait_run(1'b1, ok);
    check("seed64_reaches_run", ok, 1);
    for (int k = 0; k < 10000; k++) begin
      get_word(1'b1, v, ok);
      d64[k] = v;
      check($sformatf("seq64[%0d]", k), v, m64[k]);
      if (!ok) break;
    end
    if64.rv_ready = 1'b0;

    for (int i = 0; i < 5; i++)
      check($sformatf("kat_w%0d_n%0d", kat[i].w64 ? 64 : 32, kat[i].n),
            kat[i].w64 ? d64[kat[i].n - 1] : d32[kat[i].n - 1], kat[i].exp);

    // Backpressure: random rv_ready, stalled rv must hold
    void'($urandom(5489));
    pulse_seed32(32'd5489);
    wait_run(1'b0, ok);
    check("bp_reaches_run", ok, 1);
    acc = 0;
    stalled = 1'b0;
    stall_rv = '0;
    for (int c = 0; c < 20000 && acc < 2000; c++) begin
      if32.rv_ready = 1'($urandom_range(0, 1));
      if (stalled) begin
        check("bp_hold_valid", if32.rv_valid, 1);
        check("bp_hold_rv", if32.rv, stall_rv);
      end
      if (if32.rv_valid && if32.rv_ready) begin
        check($sformatf("bp_seq[%0d]", acc), if32.rv, m32[acc]);
        acc++;
        stalled = 1'b0;
      end else if (if32.rv_valid) begin
        stalled = 1'b1;
        stall_rv = {32'h0, if32.rv};
      end else begin
        stalled = 1'b0;
      end
      step();
    end
    check("bp_accepted", 64'(acc), 64'd2000);

    // External load from RUN with gaps between words
    if32.rv_ready = 1'b0;
    for (int i = 0; i < 624; i++) lw[i] = $urandom;
    load_words(0, 1'b1);
    model_load();
    if32.rv_ready = 1'b1;
    draw_vs_model("load", 10);

    // seed_en at draw 100 restarts the sequence
    pulse_seed32(32'd5489);
    wait_run(1'b0, ok);
    for (int k = 0; k < 100; k++) begin
      get_word(1'b0, v, ok);
      check($sformatf("pre_abort[%0d]", k), v, m32[k]);
    end
    pulse_seed32(32'd5489);
    check("abort_rv_valid", if32.rv_valid, 0);
    check("abort_sv", sv32, 0);
    check("abort_busy", busy32, 1);
    wait_run(1'b0, ok);
    check("restart_run", ok, 1);
    get_word(1'b0, v, ok);
    check("restart_first", v, 64'd3499211612);

    // load_value mid-SEED aborts to LOAD at index 0
    pulse_seed32(32'd1234);
    repeat (5) step();
    for (int i = 0; i < 624; i++) lw[i] = $urandom;
    value32 = lw[0];
    load_value32 = 1'b1;
    step();
    load_value32 = 1'b0;
    check("seed_abort_busy", busy32, 1);
    check("seed_abort_sv", sv32, 0);
    load_words(1, 1'b0);
    model_load();
    draw_vs_model("midseed_load", 5);

    // seed_en and load_value together: seed wins
    seed32 = 32'd5489;
    value32 = 32'hDEAD_BEEF;
    seed_en32 = 1'b1;
    load_value32 = 1'b1;
    step();
    seed_en32 = 1'b0;
    load_value32 = 1'b0;
    wait_run(1'b0, ok);
    check("both_reaches_run", ok, 1);
    get_word(1'b0, v, ok);
    check("both_first", v, m32[0]);
    get_word(1'b0, v, ok);
    check("both_second", v, m32[1]);
    repeat (3) step();

    // Asynchronous reset mid-RUN
    check("pre_reset_valid", if32.rv_valid, 1);
    n_rst = 1'b0;
    #2;
    check("async_rst_rv_valid", if32.rv_valid, 0);
    check("async_rst_rv", if32.rv, 0);
    check("async_rst_sv", sv32, 0);
    check("async_rst_busy", busy32, 0);
`ifdef MT_GEN_COUNT_EN
    check("async_rst_gen_count", gc32, 0);
`endif
    step();
    n_rst = 1'b1;
    if32.rv_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if32.rv_valid) seen = 1'b1;
      step();
    end
    check("no_valid_without_seed", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
